idelay_sweeper: RTL and testbench

IDELAY_SWEEPER -- requirements
Module: idelay_sweeper

---
 rtl/idelay_sweeper.sv | 234 +++++++++++++++++++++++
 tb/tb_idelay_sweeper.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/idelay_sweeper.sv
// ----------------------------------------------------------------------------
// idelay_sweeper
//
// Walks an IDELAYE2 through all 32 taps. At each tap it loads the tap value,
// waits for the delay line to settle, and then counts how often the
// resynchronised delayed data is 1 on alternate cycles. That count is reduced
// to a single bit per tap. The first tap whose bit differs from tap 0 is
// reported as the data edge.
//
// Optional feature (compile-time macro IDELAY_SWEEPER_HIST_EN):
//   defined     -> a 32-entry register array keeps each tap's ones count;
//                  hist_data = entry[hist_addr], registered, 1-cycle latency
//   not defined -> no array, hist_data tied to 0, hist_addr ignored
//
// Ports
//   clk         clock shared with IDELAYE2 C pin and the data pattern source
//   RST         synchronous active-high reset
//   cal_rdy     IDELAYCTRL ready; dropping it mid-sweep aborts the sweep
//   start       single-cycle sweep request (IDLE or DONE only)
//   dly_in      IDELAYE2 DATAOUT, asynchronous to clk
//   dly_ld      IDELAYE2 LD strobe (high for the one LOAD cycle per tap)
//   dly_cnt     IDELAYE2 CNTVALUEIN (current / last loaded tap)
//   busy        sweep in progress
//   done        sweep completed
//   abort       one-cycle pulse when cal_rdy drops during a sweep
//   edge_found  a tap differing from tap 0 was seen
//   edge_tap    first such tap (0 when none)
//   hist_addr   histogram read address
//   hist_data   histogram read data
// ----------------------------------------------------------------------------
module idelay_sweeper #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             RST,
    input  logic                             cal_rdy,
    input  logic                             start,
    input  logic                             dly_in,
    output logic                             dly_ld,
    output logic [4:0]                       dly_cnt,
    output logic                             busy,
    output logic                             done,
    output logic                             abort,
    output logic                             edge_found,
    output logic [4:0]                       edge_tap,
    input  logic [4:0]                       hist_addr,
    output logic [$clog2(SAMPLE_CYCLES)-1:0] hist_data
);

    localparam int CW = $clog2(SAMPLE_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // One counter serves both the settle and the sample windows.
    localparam logic [12:0] SETTLE_LAST = 13'(SETTLE_CYCLES - 1);
    localparam logic [12:0] SAMPLE_LAST = 13'(SAMPLE_CYCLES - 1);
    // Only half the sample cycles are counted, so a quarter is the midpoint.
    localparam logic [CW-1:0] QUARTER   = CW'(SAMPLE_CYCLES / 4);

    logic [2:0]    state_reg, state_next;
    logic [4:0]    tap_reg, tap_next;
    logic [12:0]   cnt_reg, cnt_next;
    logic          phase_reg, phase_next;
    logic [CW-1:0] ones_reg, ones_next;
    logic          ref_reg, ref_next;
    logic          edge_found_reg, edge_found_next;
    logic [4:0]    edge_tap_reg, edge_tap_next;
    logic          abort_reg, abort_next;
    logic [1:0]    sync_reg;

    logic          in_sweep;
    logic          tap_value;

    assign in_sweep  = (state_reg == S_LOAD) || (state_reg == S_SETTLE) ||
                       (state_reg == S_SAMPLE) || (state_reg == S_EVAL);
    assign tap_value = (ones_reg > QUARTER);

    // Two-flop resynchroniser for the asynchronous delayed data.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], dly_in};
        end
    end

    always_comb begin
        state_next      = state_reg;
        tap_next        = tap_reg;
        cnt_next        = cnt_reg;
        phase_next      = phase_reg;
        ones_next       = ones_reg;
        ref_next        = ref_reg;
        edge_found_next = edge_found_reg;
        edge_tap_next   = edge_tap_reg;
        abort_next      = 1'b0;

        if (in_sweep && !cal_rdy) begin
            // Losing calibration invalidates every tap measured so far.
            state_next      = S_IDLE;
            abort_next      = 1'b1;
            edge_found_next = 1'b0;
            edge_tap_next   = 5'd0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start && cal_rdy) begin
                        state_next      = S_LOAD;
                        tap_next        = 5'd0;
                        edge_found_next = 1'b0;
                        edge_tap_next   = 5'd0;
                    end
                end
                S_LOAD: begin
                    state_next = S_SETTLE;
                    cnt_next   = 13'd0;
                end
                S_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        state_next = S_SAMPLE;
                        cnt_next   = 13'd0;
                        phase_next = 1'b0;
                        ones_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + 13'd1;
                    end
                end
                S_SAMPLE: begin
                    phase_next = ~phase_reg;
                    if (phase_reg && sync_reg[1]) begin
                        ones_next = ones_reg + 1'b1;
                    end
                    if (cnt_reg == SAMPLE_LAST) begin
                        state_next = S_EVAL;
                    end else begin
                        cnt_next = cnt_reg + 13'd1;
                    end
                end
                S_EVAL: begin
                    if (tap_reg == 5'd0) begin
                        ref_next = tap_value;
                    end else if ((tap_value != ref_reg) && !edge_found_reg) begin
                        edge_found_next = 1'b1;
                        edge_tap_next   = tap_reg;
                    end
                    // Stop at the last tap rather than letting the 5-bit tap wrap.
                    if (tap_reg == 5'd31) begin
                        state_next = S_DONE;
                    end else begin
                        tap_next   = tap_reg + 5'd1;
                        state_next = S_LOAD;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg      <= S_IDLE;
            tap_reg        <= 5'd0;
            cnt_reg        <= 13'd0;
            phase_reg      <= 1'b0;
            ones_reg       <= '0;
            ref_reg        <= 1'b0;
            edge_found_reg <= 1'b0;
            edge_tap_reg   <= 5'd0;
            abort_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tap_reg        <= tap_next;
            cnt_reg        <= cnt_next;
            phase_reg      <= phase_next;
            ones_reg       <= ones_next;
            ref_reg        <= ref_next;
            edge_found_reg <= edge_found_next;
            edge_tap_reg   <= edge_tap_next;
            abort_reg      <= abort_next;
        end
    end

    // tap_reg only changes on entry to LOAD, so it also holds the last
    // loaded tap while idle or done.
    assign dly_ld     = (state_reg == S_LOAD);
    assign dly_cnt    = tap_reg;
    assign busy       = in_sweep;
    assign done       = (state_reg == S_DONE);
    assign abort      = abort_reg;
    assign edge_found = edge_found_reg;
    assign edge_tap   = edge_tap_reg;

`ifdef IDELAY_SWEEPER_HIST_EN
    logic [CW-1:0] hist_entries [0:31];
    logic [CW-1:0] hist_rd_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_hist
            logic [CW-1:0] entry_reg;
            // Histogram contents are not reset; only written at EVAL.
            always_ff @(posedge clk) begin
                if (!RST && (state_reg == S_EVAL) && (tap_reg == 5'(gi))) begin
                    entry_reg <= ones_reg;
                end
            end
            assign hist_entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (RST) begin
            hist_rd_reg <= '0;
        end else begin
            hist_rd_reg <= hist_entries[hist_addr];
        end
    end

    assign hist_data = hist_rd_reg;
`else
    logic unused_hist_addr;
    assign unused_hist_addr = ^hist_addr;
    assign hist_data        = '0;
`endif

endmodule

// File: tb/tb_idelay_sweeper.sv
// ----------------------------------------------------------------------------
// tb_idelay_sweeper
//
// Drives idelay_sweeper with SETTLE_CYCLES=4, SAMPLE_CYCLES=16 (22 cycles per
// tap, 704 per sweep). dly_in is a toggle pattern that changes on the falling
// edge; optionally it is inverted for taps >= 13 to model a data edge.
// A timeline model computes, from the cycle index since the start edge, what
// every status output must be, and is compared on each falling edge while a
// sweep runs. Directed checks cover reset, abort, mid-sweep reset, ignored
// start requests and the histogram readback.
// ----------------------------------------------------------------------------
module tb_idelay_sweeper;

    localparam int SETTLE  = 4;
    localparam int SAMPLE  = 16;
    localparam int TAP_CYC = 2 + SETTLE + SAMPLE;
    localparam int SWEEP   = 32 * TAP_CYC;
    localparam int EDGE_AT = 13;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       cal_rdy = 1'b1;
    logic       start = 1'b0;
    logic       dly_in = 1'b0;
    logic       dly_ld;
    logic [4:0] dly_cnt;
    logic       busy;
    logic       done;
    logic       abort;
    logic       edge_found;
    logic [4:0] edge_tap;
    logic [4:0] hist_addr = 5'd0;
    logic [3:0] hist_data;

    int compared   = 0;
    int mismatched = 0;

    logic m_active = 1'b0;
    int   m_t      = 0;
    logic inv_en   = 1'b0;
    logic tog      = 1'b0;
    int   ld_pulses = 0;
    int   done_t    = 0;

    idelay_sweeper #(
        .SETTLE_CYCLES(SETTLE),
        .SAMPLE_CYCLES(SAMPLE)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .cal_rdy   (cal_rdy),
        .start     (start),
        .dly_in    (dly_in),
        .dly_ld    (dly_ld),
        .dly_cnt   (dly_cnt),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .edge_found(edge_found),
        .edge_tap  (edge_tap),
        .hist_addr (hist_addr),
        .hist_data (hist_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Delay-line model: clk-rate toggle pattern, inverted at taps >= EDGE_AT.
    always @(negedge clk) begin
        tog    = ~tog;
        dly_in = tog ^ (inv_en && (dly_cnt >= 5'(EDGE_AT)));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: cycle n after the start edge belongs to tap n/22, and
    // position 0 within a tap is the LOAD cycle.
    always @(negedge clk) begin : cmp
        int n;
        logic [14:0] e;
        logic [14:0] a;
        logic       ef;
        if (m_active) begin
            m_t++;
            n = m_t - 1;
            if (dly_ld) ld_pulses++;
            if (done && done_t == 0) done_t = m_t;
            if (n < SWEEP) begin
                ef = inv_en && (n >= TAP_CYC * (EDGE_AT + 1));
                e  = {(n % TAP_CYC) == 0, 5'(n / TAP_CYC), 1'b1, 1'b0, 1'b0,
                      ef, ef ? 5'(EDGE_AT) : 5'd0};
            end else begin
                ef = inv_en;
                e  = {1'b0, 5'd31, 1'b0, 1'b1, 1'b0, ef, ef ? 5'(EDGE_AT) : 5'd0};
            end
            a = {dly_ld, dly_cnt, busy, done, abort, edge_found, edge_tap};
            check($sformatf("timeline t=%0d {ld,cnt,busy,done,abort,ef,tap}", m_t), 32'(a), 32'(e));
        end
    end

    // Start a sweep with the pattern phased so counted samples see a 1.
    task automatic do_start(input logic inv);
        @(negedge clk);
        #1;
        if (tog) begin
            @(negedge clk);
            #1;
        end
        inv_en    = inv;
        ld_pulses = 0;
        done_t    = 0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        m_t      = 0;
        m_active = 1'b1;
    endtask

    task automatic sweep(input logic inv, input logic poke);
        do_start(inv);
        if (poke) begin
            repeat (7 * TAP_CYC + 3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (SWEEP + 2 - (7 * TAP_CYC + 4)) @(posedge clk);
        end else begin
            repeat (SWEEP + 2) @(posedge clk);
        end
        #1 m_active = 1'b0;
        check("ld_pulse_count", 32'(ld_pulses), 32'd32);
        check("done_first_cycle", 32'(done_t), 32'd705);
        check("final_dly_cnt", 32'(dly_cnt), 32'd31);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dly_ld"}, 32'(dly_ld), 32'd0);
        check({tag, "_dly_cnt"}, 32'(dly_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_abort"}, 32'(abort), 32'd0);
        check({tag, "_edge_found"}, 32'(edge_found), 32'd0);
        check({tag, "_edge_tap"}, 32'(edge_tap), 32'd0);
    endtask

    task automatic read_hist(input logic [4:0] addr, input logic [3:0] exp);
        hist_addr = addr;
        @(posedge clk);
        #1;
        check($sformatf("hist[%0d]", addr), 32'(hist_data), 32'(exp));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;

        // start with calibration not ready is ignored
        cal_rdy = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("nordy_busy", 32'(busy), 32'd0);
            check("nordy_ld", 32'(dly_ld), 32'd0);
        end
        cal_rdy = 1'b1;

        // plain sweep, with an extra start during tap 7 that must be ignored
        sweep(1'b0, 1'b1);
        check("plain_edge_found", 32'(edge_found), 32'd0);
        check("plain_edge_tap", 32'(edge_tap), 32'd0);

        // edge at tap 13, restarted from DONE
        sweep(1'b1, 1'b0);
        check("edge_found_lit", 32'(edge_found), 32'd1);
        check("edge_tap_lit", 32'(edge_tap), 32'd13);
`ifdef IDELAY_SWEEPER_HIST_EN
        read_hist(5'd12, 4'd8);
        read_hist(5'd13, 4'd0);
        read_hist(5'd0, 4'd8);
        read_hist(5'd31, 4'd0);
`else
        read_hist(5'd12, 4'd0);
        read_hist(5'd0, 4'd0);
`endif

        // cal_rdy drop in SAMPLE of tap 5
        do_start(1'b0);
        repeat (5 * TAP_CYC + 10) @(posedge clk);
        #1;
        m_active = 1'b0;
        cal_rdy  = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_edge_found", 32'(edge_found), 32'd0);
        check("abort_dly_cnt", 32'(dly_cnt), 32'd5);
        check("abort_ld", 32'(dly_ld), 32'd0);
        @(posedge clk);
        #1;
        check("abort_width", 32'(abort), 32'd0);
        cal_rdy = 1'b1;

        // reset during SETTLE of tap 20, after the edge has been found
        do_start(1'b1);
        repeat (20 * TAP_CYC + 2) @(posedge clk);
        #1;
        m_active = 1'b0;
        check("pre_reset_edge_found", 32'(edge_found), 32'd1);
        RST = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        RST = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("post_reset_no_ld", 32'(dly_ld), 32'd0);
        end

        // fresh sweep after reset starts again at tap 0
        sweep(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
